audio_i2s_link: RTL and testbench
=================================

# audio_i2s_link

Bidirectional I2S link between the sound mixer and the external audio codec. It runs on the 12 MHz codec master clock and generates the bit clock and word clock for both directions. It serializes one 16-bit left/right DAC sample pair per frame and deserializes the codec ADC stream into 16-bit words for the tape-input comparator. Frame length is 256 `clk12` cycles, giving a 46.875 kHz sample rate.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `iAUD_ADCDAT` before capture. Legal values are 2 and 3.

Ports:
- `clk12`  in  1  12 MHz clock. This is the only clock.
- `reset`  in  1  Synchronous, active-high reset.
- `sample_l`  in  16  Left DAC sample, two's complement.
- `sample_r`  in  16  Right DAC sample, two's complement.
- `sample_strobe`  out  1  One-cycle pulse: the sample pair was latched on the previous edge. Upstream may change `sample_l`/`sample_r` from this point.
- `adc_l`  out  16  Last received left ADC word.
- `adc_r`  out  16  Last received right ADC word.
- `adc_valid`  out  1  One-cycle pulse: `adc_l`/`adc_r` were updated.
- `oAUD_BCK`  out  1  Bit clock, `clk12`/4.
- `oAUD_LRCK`  out  1  DAC word clock. 0 = left, 1 = right.
- `oAUD_ADCLRCK`  out  1  ADC word clock. Identical to `oAUD_LRCK`.
- `oAUD_DATA`  out  1  DAC serial data.
- `iAUD_ADCDAT`  in  1  ADC serial data. Asynchronous.

## Operation
- **Frame counter** `cnt[7:0]`: increments every cycle and wraps 255→0.
  - `oAUD_BCK = cnt[1]`.
  - `oAUD_LRCK = oAUD_ADCLRCK = cnt[7]`.
  - Bit slot `s = cnt[6:2]` (0..31) within each half-frame.
- **Sample latch**: on the edge where `cnt==255`, `hold_l<=sample_l` and `hold_r<=sample_r`. `sample_strobe` is 1 exactly while `cnt==0`.
- **Transmit**: 16-bit shifter `tx`, with `oAUD_DATA = tx[15]`.
  - On the edge where `cnt==3`, `tx<=hold_l`.
  - On the edge where `cnt==131`, `tx<=hold_r`.
  - On every other edge where `cnt[1:0]==3`, `tx<={tx[14:0],1'b0}`.
  - Result: MSB appears in slot 1 (I2S one-BCK delay), slots 1..16 carry bits 15..0, and slots 17..31 and slot 0 carry 0.
  - `oAUD_DATA` changes only on BCK falling edges.
- **Receive**:
  - `iAUD_ADCDAT` passes through `SYNC_STAGES` flops to produce `adat`.
  - On edges where `cnt[1:0]==3` and `s` is in 1..16, `rx<={rx[14:0],adat}`.
  - On the edge where `cnt==67`, `adc_l<={rx[14:0],adat}`.
  - On the edge where `cnt==195`, `adc_r<={rx[14:0],adat}`. `adc_valid` is 1 exactly while `cnt==196`.
- **Reset**:
  - `cnt`, `hold_*`, `tx`, `rx`, `adc_l`, `adc_r`, the sync flops and all pulses go to 0.
  - Therefore `oAUD_BCK`, `oAUD_LRCK`, `oAUD_ADCLRCK`, `oAUD_DATA`, `sample_strobe` and `adc_valid` are all 0 in the cycle after reset.
  - Reset mid-frame aborts the frame. The next frame starts at `cnt==0` and transmits zeros in its first frame, because `hold_*` is 0.
- No backpressure exists. Upstream values are sampled unconditionally at `cnt==255`. A sample change coinciding with that edge is captured with its new value.

## Timing
- BCK period is 4 cycles: low for `cnt[1:0]` = 0,1 and high for 2,3. LRCK period is 256 cycles.
- DAC latency: a sample present at the `cnt==255` edge emits its left MSB on `oAUD_DATA` during `cnt` 4..7 and its right MSB during `cnt` 132..135.
- ADC latency: with `SYNC_STAGES=2`, a pin value is captured in the slot where it was present at the `cnt[1:0]==1` edge.
- `adc_l` and `adc_r` are stable except on their single update edge. Consumers must not rely on `adc_valid` for `adc_l` alone.

## Configuration
- `AUDIO_I2S_ADC_EN`
  - Defined: the receive path operates as above.
  - Undefined: the sync flops, `rx` and the ADC registers are not built. `adc_l`, `adc_r` and `adc_valid` are tied to 0, and `iAUD_ADCDAT` is ignored. The transmit path and clocks are unchanged.

## Test plan
- Reset, then release for 512 cycles. `oAUD_BCK` toggles every 2 cycles and `oAUD_LRCK` every 128 cycles. `sample_strobe` pulses at cycles 256 and 512 after release.
- `sample_l=16'hA5C3`, `sample_r=16'h0001`, held. In the second frame, `oAUD_DATA` in slots 1..16 of the left half reads 1010010111000011, the right half reads 15 zeros then 1, and all other slots read 0.
- Drive `iAUD_ADCDAT` from a model sending left `16'h8001` and right `16'h7FFE` on BCK falling edges, MSB in slot 1. After the frame, `adc_l==16'h8001`, `adc_r==16'h7FFE`, and `adc_valid` pulses once at `cnt==196`.
- Assert `reset` for one cycle at `cnt==100` with `sample_l` nonzero. `cnt` restarts at 0, `oAUD_DATA` stays 0 for the first frame, and the correct data appears in the next frame.
- Change `sample_l` in the same cycle as `cnt==255`. The new value is transmitted in the following left half.
- Build without `AUDIO_I2S_ADC_EN` and toggle `iAUD_ADCDAT` randomly. `adc_l`, `adc_r` and `adc_valid` stay 0, and the DAC output is identical to the configured build.

Source files
------------

// File: rtl/audio_i2s_link.sv
// rtl/audio_i2s_link.sv - I2S DAC/ADC link on the 12 MHz codec clock, 256-cycle frames.
// Receive path is built only when AUDIO_I2S_ADC_EN is defined.
module audio_i2s_link #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    output logic        sample_strobe,
    output logic [15:0] adc_l,
    output logic [15:0] adc_r,
    output logic        adc_valid,
    output logic        oAUD_BCK,
    output logic        oAUD_LRCK,
    output logic        oAUD_ADCLRCK,
    output logic        oAUD_DATA,
    input  logic        iAUD_ADCDAT
);

    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;
    logic [15:0] tx_q, tx_d;
    logic        strobe_q, strobe_d;

    always_comb begin
        cnt_d    = cnt_q + 8'd1;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        strobe_d = (cnt_q == 8'hFF);
        tx_d     = tx_q;
        if (cnt_q == 8'hFF) begin
            hold_l_d = sample_l;
            hold_r_d = sample_r;
        end
        // Loading at the end of slot 0 gives the one-BCK I2S delay before the MSB.
        if (cnt_q == 8'd3) begin
            tx_d = hold_l_q;
        end else if (cnt_q == 8'd131) begin
            tx_d = hold_r_q;
        end else if (cnt_q[1:0] == 2'd3) begin
            tx_d = {tx_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            cnt_q    <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            tx_q     <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign oAUD_BCK      = cnt_q[1];
    assign oAUD_LRCK     = cnt_q[7];
    assign oAUD_ADCLRCK  = cnt_q[7];
    assign oAUD_DATA     = tx_q[15];

`ifdef AUDIO_I2S_ADC_EN
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            rx_q, rx_d;
    logic [15:0]            adc_l_q, adc_l_d;
    logic [15:0]            adc_r_q, adc_r_d;
    logic                   valid_q, valid_d;
    logic                   adat;
    logic [4:0]             slot;
    logic                   capture;

    assign adat    = sync_q[SYNC_STAGES-1];
    assign slot    = cnt_q[6:2];
    assign capture = (cnt_q[1:0] == 2'd3) && (slot >= 5'd1) && (slot <= 5'd16);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], iAUD_ADCDAT};
        rx_d    = rx_q;
        adc_l_d = adc_l_q;
        adc_r_d = adc_r_q;
        valid_d = (cnt_q == 8'd195);
        if (capture) begin
            rx_d = {rx_q[14:0], adat};
        end
        // Slot 16 ends at 67/195: the word completes with the bit arriving this edge.
        if (cnt_q == 8'd67) begin
            adc_l_d = {rx_q[14:0], adat};
        end
        if (cnt_q == 8'd195) begin
            adc_r_d = {rx_q[14:0], adat};
        end
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            sync_q  <= '0;
            rx_q    <= '0;
            adc_l_q <= '0;
            adc_r_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            rx_q    <= rx_d;
            adc_l_q <= adc_l_d;
            adc_r_q <= adc_r_d;
            valid_q <= valid_d;
        end
    end

    assign adc_l     = adc_l_q;
    assign adc_r     = adc_r_q;
    assign adc_valid = valid_q;
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {iAUD_ADCDAT, (SYNC_STAGES == 3)};
    assign adc_l      = '0;
    assign adc_r      = '0;
    assign adc_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_i2s_link.sv
// tb/tb_audio_i2s_link.sv - scoreboard bench for audio_i2s_link (DAC frames, ADC words, clocks, reset).
module tb_audio_i2s_link;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_l = '0;
    logic [15:0] sample_r = '0;
    logic        iAUD_ADCDAT = 1'b0;
    logic        sample_strobe;
    logic [15:0] adc_l;
    logic [15:0] adc_r;
    logic        adc_valid;
    logic        oAUD_BCK;
    logic        oAUD_LRCK;
    logic        oAUD_ADCLRCK;
    logic        oAUD_DATA;

`ifdef AUDIO_I2S_ADC_EN
    localparam bit ADC_EN = 1'b1;
`else
    localparam bit ADC_EN = 1'b0;
`endif

    audio_i2s_link #(.SYNC_STAGES(2)) dut (
        .clk12        (clk12),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_strobe(sample_strobe),
        .adc_l        (adc_l),
        .adc_r        (adc_r),
        .adc_valid    (adc_valid),
        .oAUD_BCK     (oAUD_BCK),
        .oAUD_LRCK    (oAUD_LRCK),
        .oAUD_ADCLRCK (oAUD_ADCLRCK),
        .oAUD_DATA    (oAUD_DATA),
        .iAUD_ADCDAT  (iAUD_ADCDAT)
    );

    always #5 clk12 = ~clk12;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] dac_q[$];
    logic [31:0] adc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame position, independent of the DUT.
    logic [7:0] tcnt = '0;
    logic       strobe_exp = 1'b0;
    always @(posedge clk12) begin
        if (reset) begin
            tcnt       <= '0;
            strobe_exp <= 1'b0;
        end else begin
            tcnt       <= tcnt + 8'd1;
            strobe_exp <= (tcnt == 8'hFF);
        end
    end

    // Codec ADC model: new bit after each BCK falling edge, MSB in slot 1.
    logic [15:0] wl = '0;
    logic [15:0] wr = '0;
    int          adc_frames = 0;
    int          mod_s;
    always @(posedge clk12) begin
        #1;
        if (!reset && tcnt[1:0] == 2'd0) begin
            if (tcnt == 8'd4) begin
                if (adc_frames == 0) begin
                    wl = 16'h8001;
                    wr = 16'h7FFE;
                end else begin
                    wl = 16'($urandom);
                    wr = 16'($urandom);
                end
                adc_frames++;
                if (ADC_EN) adc_q.push_back({wl, wr});
            end
            mod_s = int'(tcnt[6:2]);
            if (mod_s >= 1 && mod_s <= 16)
                iAUD_ADCDAT = tcnt[7] ? wr[16-mod_s] : wl[16-mod_s];
            else
                iAUD_ADCDAT = 1'($urandom_range(0, 1));
        end
    end

    logic [15:0] cap_l = '0;
    logic [15:0] cap_r = '0;
    logic [31:0] exp_pair;
    logic        prev_data = 1'b0;
    bit          prev_ok = 1'b0;
    int          mon_s;
    always @(negedge clk12) begin
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            check("bck", oAUD_BCK, tcnt[1]);
            check("lrck", oAUD_LRCK, tcnt[7]);
            check("adclrck", oAUD_ADCLRCK, tcnt[7]);
            check("sample_strobe", sample_strobe, strobe_exp);
            if (prev_ok && tcnt[1:0] != 2'd0) check("data_stable", oAUD_DATA, prev_data);
            prev_data = oAUD_DATA;
            prev_ok   = 1'b1;

            if (tcnt == 8'd0) begin
                cap_l = '0;
                cap_r = '0;
            end
            if (tcnt[1:0] == 2'd2) begin
                mon_s = int'(tcnt[6:2]);
                if (mon_s >= 1 && mon_s <= 16) begin
                    if (tcnt[7]) cap_r = {cap_r[14:0], oAUD_DATA};
                    else         cap_l = {cap_l[14:0], oAUD_DATA};
                end else begin
                    check("dac_idle_slot", oAUD_DATA, 1'b0);
                end
            end
            if (tcnt == 8'hFF) begin
                check("dac_sb_nonempty", dac_q.size() > 0, 1);
                if (dac_q.size() > 0) begin
                    exp_pair = dac_q.pop_front();
                    check("dac_left", cap_l, exp_pair[31:16]);
                    check("dac_right", cap_r, exp_pair[15:0]);
                end
            end

            if (ADC_EN) begin
                check("adc_valid", adc_valid, tcnt == 8'd196);
                if (adc_valid) begin
                    check("adc_sb_nonempty", adc_q.size() > 0, 1);
                    if (adc_q.size() > 0) begin
                        exp_pair = adc_q.pop_front();
                        check("adc_l", adc_l, exp_pair[31:16]);
                        check("adc_r", adc_r, exp_pair[15:0]);
                    end
                end
            end else begin
                check("adc_l_tied", adc_l, 16'h0);
                check("adc_r_tied", adc_r, 16'h0);
                check("adc_valid_tied", adc_valid, 1'b0);
            end
        end
    end

    task automatic wait_cnt(input logic [7:0] c);
        do begin
            @(posedge clk12);
            #1;
        end while (tcnt != c);
    endtask

    task automatic set_pair(input logic [15:0] l, input logic [15:0] r, input bit push);
        sample_l = l;
        sample_r = r;
        if (push) dac_q.push_back({l, r});
    endtask

    initial begin
        dac_q.push_back(32'h0);
        repeat (3) @(posedge clk12);
        #1 reset = 1'b0;

        @(negedge clk12);
        check("rst_bck", oAUD_BCK, 1'b0);
        check("rst_lrck", oAUD_LRCK, 1'b0);
        check("rst_adclrck", oAUD_ADCLRCK, 1'b0);
        check("rst_data", oAUD_DATA, 1'b0);
        check("rst_strobe", sample_strobe, 1'b0);
        check("rst_adc_valid", adc_valid, 1'b0);
        check("rst_adc_l", adc_l, 16'h0);
        check("rst_adc_r", adc_r, 16'h0);

        wait_cnt(8'd10);
        set_pair(16'hA5C3, 16'h0001, 1'b1);
        wait_cnt(8'd10);
        set_pair(16'h8000, 16'hFFFF, 1'b1);
        wait_cnt(8'd10);
        set_pair(16'h0F0F, 16'hF0F0, 1'b0);
        wait_cnt(8'hFF);
        set_pair(16'h3C3C, 16'hF0F0, 1'b1);
        wait_cnt(8'd10);
        set_pair(16'h7777, 16'h1111, 1'b1);

        wait_cnt(8'd100);
        reset = 1'b1;
        dac_q.delete();
        adc_q.delete();
        dac_q.push_back(32'h0);
        dac_q.push_back({16'h7777, 16'h1111});
        @(posedge clk12);
        #1 reset = 1'b0;

        wait_cnt(8'hFF);
        wait_cnt(8'hFF);
        wait_cnt(8'd2);
        check("dac_sb_drained", dac_q.size(), 0);
        check("adc_sb_drained", adc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
